rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 37 +++
 rtl/rf_write_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bundles the FU-side request bus and RF-side write-port bus of rf_write_arbiter.
// Ports (slave = arbiter side): fu2arb_write_{vld,reg_id,data} in, fu2arb_write_rdy out,
//   arb2rf_write_rdy in, arb2rf_write_{vld,reg_id,data,fu} out, reg_write_back out.
interface rf_write_arbiter_if #(
  parameter int NUM_FU      = 4,
  parameter int NUM_WR_PORT = 2,
  parameter int REG_BIT     = 16,
  parameter int NUM_REG     = 8
);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int FU_ID_BIT  = $clog2(NUM_FU);

  logic [NUM_FU-1:0]                 fu2arb_write_vld;
  logic [NUM_FU-1:0]                 fu2arb_write_rdy;
  logic [NUM_FU*REG_ID_BIT-1:0]      fu2arb_write_reg_id;
  logic [NUM_FU*REG_BIT-1:0]         fu2arb_write_data;
  logic [NUM_WR_PORT-1:0]            arb2rf_write_vld;
  logic [NUM_WR_PORT-1:0]            arb2rf_write_rdy;
  logic [NUM_WR_PORT*REG_ID_BIT-1:0] arb2rf_write_reg_id;
  logic [NUM_WR_PORT*REG_BIT-1:0]    arb2rf_write_data;
  logic [NUM_WR_PORT*FU_ID_BIT-1:0]  arb2rf_write_fu;
  logic [NUM_REG-1:0]                reg_write_back;

  // Arbiter side.
  modport slave (
    input  fu2arb_write_vld, fu2arb_write_reg_id, fu2arb_write_data, arb2rf_write_rdy,
    output fu2arb_write_rdy, arb2rf_write_vld, arb2rf_write_reg_id, arb2rf_write_data,
           arb2rf_write_fu, reg_write_back
  );

  // Environment side (FUs + register file).
  modport master (
    output fu2arb_write_vld, fu2arb_write_reg_id, fu2arb_write_data, arb2rf_write_rdy,
    input  fu2arb_write_rdy, arb2rf_write_vld, arb2rf_write_reg_id, arb2rf_write_data,
           arb2rf_write_fu, reg_write_back
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter funnelling NUM_FU write requests onto NUM_WR_PORT register-file ports.
// Latency: 1 cycle from FU handshake to arb2rf_write_vld; a port drains and refills in one cycle.
// Backpressure: a port held by !arb2rf_write_rdy keeps its entry stable; FUs are granted only onto free ports.
// Ports: clk, rst (async, active high); arb_if (slave modport) carries the FU request bus,
//   the per-port RF write bus with source-FU tag, and the reg_write_back completion vector.
module rf_write_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int NUM_WR_PORT = 2,
  parameter int REG_BIT     = 16,
  parameter int NUM_REG     = 8
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave arb_if
);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int FU_ID_BIT  = $clog2(NUM_FU);

  typedef struct packed {
    logic                  vld;
    logic [REG_ID_BIT-1:0] reg_id;
    logic [REG_BIT-1:0]    data;
    logic [FU_ID_BIT-1:0]  fu;
  } hold_t;

  hold_t                  hold_q [NUM_WR_PORT];
  hold_t                  hold_d [NUM_WR_PORT];
  logic [FU_ID_BIT-1:0]   rr_ptr_q;
  logic [FU_ID_BIT-1:0]   rr_ptr_d;
  logic [NUM_WR_PORT-1:0] port_fire;
  logic [NUM_WR_PORT-1:0] port_free;
  logic [NUM_WR_PORT-1:0] port_load;
  logic [FU_ID_BIT-1:0]   port_src [NUM_WR_PORT];
  logic [NUM_FU-1:0]      grant;

  // A port is free when empty or when its entry is being accepted right now,
  // which lets it refill in the same cycle it drains.
  always_comb begin
    port_fire = '0;
    port_free = '0;
    for (int p = 0; p < NUM_WR_PORT; p++) begin
      port_fire[p] = hold_q[p].vld & arb_if.arb2rf_write_rdy[p];
      port_free[p] = ~hold_q[p].vld | port_fire[p];
    end
  end

  // Scan FUs starting at rr_ptr; each requester takes the lowest-index free port
  // not yet claimed this cycle. Grants never look at fu2arb_write_rdy.
  always_comb begin
    logic [NUM_WR_PORT-1:0] taken;
    logic                   placed;
    logic [FU_ID_BIT-1:0]   idx;
    grant     = '0;
    port_load = '0;
    taken     = '0;
    placed    = 1'b0;
    idx       = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int p = 0; p < NUM_WR_PORT; p++) begin
      port_src[p] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      idx    = FU_ID_BIT'((int'(rr_ptr_q) + k) % NUM_FU);
      placed = 1'b0;
      if (arb_if.fu2arb_write_vld[idx]) begin
        for (int p = 0; p < NUM_WR_PORT; p++) begin
          if (!placed && port_free[p] && !taken[p]) begin
            taken[p]     = 1'b1;
            placed       = 1'b1;
            port_load[p] = 1'b1;
            port_src[p]  = idx;
          end
        end
        if (placed) begin
          grant[idx] = 1'b1;
          rr_ptr_d   = FU_ID_BIT'((int'(idx) + 1) % NUM_FU);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_WR_PORT; p++) begin
      hold_d[p] = hold_q[p];
      if (port_load[p]) begin
        hold_d[p].vld    = 1'b1;
        hold_d[p].reg_id = arb_if.fu2arb_write_reg_id[int'(port_src[p])*REG_ID_BIT +: REG_ID_BIT];
        hold_d[p].data   = arb_if.fu2arb_write_data[int'(port_src[p])*REG_BIT +: REG_BIT];
        hold_d[p].fu     = port_src[p];
      end else if (port_free[p]) begin
        hold_d[p].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int p = 0; p < NUM_WR_PORT; p++) begin
        hold_q[p] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int p = 0; p < NUM_WR_PORT; p++) begin
        hold_q[p] <= hold_d[p];
      end
    end
  end

  // Ports are all free while in reset, so the raw grant vector is masked here.
  assign arb_if.fu2arb_write_rdy = rst ? '0 : grant;

  always_comb begin
    arb_if.arb2rf_write_vld    = '0;
    arb_if.arb2rf_write_reg_id = '0;
    arb_if.arb2rf_write_data   = '0;
    arb_if.arb2rf_write_fu     = '0;
    arb_if.reg_write_back      = '0;
    for (int p = 0; p < NUM_WR_PORT; p++) begin
      arb_if.arb2rf_write_vld[p]                            = hold_q[p].vld;
      arb_if.arb2rf_write_reg_id[p*REG_ID_BIT +: REG_ID_BIT] = hold_q[p].reg_id;
      arb_if.arb2rf_write_data[p*REG_BIT +: REG_BIT]         = hold_q[p].data;
      arb_if.arb2rf_write_fu[p*FU_ID_BIT +: FU_ID_BIT]       = hold_q[p].fu;
      // Register 0 is hardwired in the RF, so its writes never signal completion.
      if (port_fire[p] && (hold_q[p].reg_id != '0)) begin
        arb_if.reg_write_back[hold_q[p].reg_id] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  localparam int NUM_FU      = 4;
  localparam int NUM_WR_PORT = 2;
  localparam int REG_BIT     = 16;
  localparam int NUM_REG     = 8;
  localparam int RB          = 3;
  localparam int FB          = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   wr_cnt = 0;

  rf_write_arbiter_if #(.NUM_FU(NUM_FU), .NUM_WR_PORT(NUM_WR_PORT),
                        .REG_BIT(REG_BIT), .NUM_REG(NUM_REG)) ifc ();

  rf_write_arbiter #(.NUM_FU(NUM_FU), .NUM_WR_PORT(NUM_WR_PORT),
                     .REG_BIT(REG_BIT), .NUM_REG(NUM_REG)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FB-1:0]      fu;
    logic [RB-1:0]      reg_id;
    logic [REG_BIT-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [REG_BIT-1:0] p_dat(input int p);
    return ifc.arb2rf_write_data[p*REG_BIT +: REG_BIT];
  endfunction
  function automatic logic [RB-1:0] p_reg(input int p);
    return ifc.arb2rf_write_reg_id[p*RB +: RB];
  endfunction
  function automatic logic [FB-1:0] p_fu(input int p);
    return ifc.arb2rf_write_fu[p*FB +: FB];
  endfunction

  task automatic set_fu(input int i, input logic v, input logic [RB-1:0] r, input logic [REG_BIT-1:0] d);
    ifc.fu2arb_write_vld[i]                    = v;
    ifc.fu2arb_write_reg_id[i*RB +: RB]        = r;
    ifc.fu2arb_write_data[i*REG_BIT +: REG_BIT] = d;
  endtask

  task automatic chk_port(input string tag, input int p, input logic v, input int fu,
                          input int r, input logic [REG_BIT-1:0] d);
    chk({tag, "_vld"}, 64'(ifc.arb2rf_write_vld[p]), 64'(v));
    chk({tag, "_fu"},  64'(p_fu(p)),  64'(fu));
    chk({tag, "_reg"}, 64'(p_reg(p)), 64'(r));
    chk({tag, "_dat"}, 64'(p_dat(p)), 64'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: an FU handshake pushes the expected RF write; an RF handshake
  // must match a queued entry, and reg_write_back must reflect exactly those writes.
  always @(negedge clk) begin : mon
    logic [NUM_REG-1:0] exp_wb;
    int hit;
    if (!rst) begin
      exp_wb = '0;
      for (int p = 0; p < NUM_WR_PORT; p++) begin
        if (ifc.arb2rf_write_vld[p] && ifc.arb2rf_write_rdy[p]) begin
          hit = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (hit < 0 && exp_q[j].data == p_dat(p)) hit = j;
          wr_cnt++;
          chk("sb_hit", 64'(hit >= 0), 64'(1));
          if (hit >= 0) begin
            chk("sb_fu",  64'(p_fu(p)),  64'(exp_q[hit].fu));
            chk("sb_reg", 64'(p_reg(p)), 64'(exp_q[hit].reg_id));
            if (exp_q[hit].reg_id != '0) exp_wb[exp_q[hit].reg_id] = 1'b1;
            exp_q.delete(hit);
          end
        end
      end
      chk("wb", 64'(ifc.reg_write_back), 64'(exp_wb));
      for (int i = 0; i < NUM_FU; i++) begin
        if (ifc.fu2arb_write_vld[i] && ifc.fu2arb_write_rdy[i])
          exp_q.push_back('{fu: FB'(i),
                            reg_id: ifc.fu2arb_write_reg_id[i*RB +: RB],
                            data: ifc.fu2arb_write_data[i*REG_BIT +: REG_BIT]});
      end
    end
  end

  initial begin
    int gnt [NUM_FU];
    int w0;
    int seq;
    ifc.fu2arb_write_vld    = '0;
    ifc.fu2arb_write_reg_id = '0;
    ifc.fu2arb_write_data   = '0;
    ifc.arb2rf_write_rdy    = '0;

    // Reset state with all FUs requesting; two FUs share reg 3.
    set_fu(0, 1'b1, 3'd3, 16'hA000);
    set_fu(1, 1'b1, 3'd3, 16'hA001);
    set_fu(2, 1'b1, 3'd6, 16'hA002);
    set_fu(3, 1'b1, 3'd7, 16'hA003);
    ifc.arb2rf_write_rdy = 2'b11;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_vld", 64'(ifc.arb2rf_write_vld), 64'(0));
    chk("rst_rdy", 64'(ifc.fu2arb_write_rdy), 64'(0));
    chk("rst_wb",  64'(ifc.reg_write_back),   64'(0));
    rst = 1'b0;
    #1;
    chk("c0_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b0011));
    tick();
    set_fu(0, 1'b1, 3'd4, 16'hB000);
    set_fu(1, 1'b1, 3'd5, 16'hB001);
    #1;
    chk("c1_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b1100));
    chk_port("c1_p0", 0, 1'b1, 0, 3, 16'hA000);
    chk_port("c1_p1", 1, 1'b1, 1, 3, 16'hA001);
    tick();
    set_fu(2, 1'b1, 3'd1, 16'hB002);
    set_fu(3, 1'b1, 3'd2, 16'hB003);
    #1;
    chk("c2_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b0011));
    chk_port("c2_p0", 0, 1'b1, 2, 6, 16'hA002);
    chk_port("c2_p1", 1, 1'b1, 3, 7, 16'hA003);
    ifc.fu2arb_write_vld = '0;
    tick();
    tick();
    #1;
    chk("c4_idle", 64'(ifc.arb2rf_write_vld), 64'(0));
    chk("c4_sb_empty", 64'(exp_q.size()), 64'(0));

    // Lone FU2 request; pointer must move to 3.
    set_fu(2, 1'b1, 3'd5, 16'hBEEF);
    #1;
    chk("q2_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b0100));
    tick();
    set_fu(0, 1'b1, 3'd1, 16'hC000);
    set_fu(1, 1'b1, 3'd2, 16'hC001);
    set_fu(2, 1'b1, 3'd4, 16'hC002);
    set_fu(3, 1'b1, 3'd6, 16'hC003);
    #1;
    chk_port("q2_p0", 0, 1'b1, 2, 5, 16'hBEEF);
    chk("q2_p1_vld", 64'(ifc.arb2rf_write_vld[1]), 64'(0));
    chk("q2_wb", 64'(ifc.reg_write_back), 64'(8'b0010_0000));
    chk("q2_rr", 64'(ifc.fu2arb_write_rdy), 64'(4'b1001));
    tick();

    // Full back-pressure for 3 cycles, then only port0 accepts.
    ifc.arb2rf_write_rdy = 2'b00;
    set_fu(3, 1'b1, 3'd6, 16'hD003);
    set_fu(0, 1'b1, 3'd1, 16'hD000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_gnt", 64'(ifc.fu2arb_write_rdy), 64'(0));
      chk_port("bp_p0", 0, 1'b1, 3, 6, 16'hC003);
      chk_port("bp_p1", 1, 1'b1, 0, 1, 16'hC000);
      tick();
    end
    ifc.arb2rf_write_rdy = 2'b01;
    #1;
    chk("rdy01_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b0010));
    tick();
    set_fu(1, 1'b1, 3'd2, 16'hD001);
    #1;
    chk_port("rdy01_p0", 0, 1'b1, 1, 2, 16'hC001);
    chk_port("rdy01_p1", 1, 1'b1, 0, 1, 16'hC000);

    // Sustained traffic, RF always ready.
    ifc.arb2rf_write_rdy = 2'b11;
    w0  = wr_cnt;
    seq = 16'h100;
    for (int i = 0; i < NUM_FU; i++) gnt[i] = 0;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < NUM_FU; i++)
        set_fu(i, 1'b1, RB'($urandom_range(0, NUM_REG-1)), {FB'(i), 14'(seq)});
      seq++;
      #1;
      chk("tput_gnt", 64'($countones(ifc.fu2arb_write_rdy)), 64'(2));
      for (int i = 0; i < NUM_FU; i++) gnt[i] += int'(ifc.fu2arb_write_rdy[i]);
      tick();
    end
    chk("tput_wr", 64'(wr_cnt - w0), 64'(200));
    for (int i = 0; i < NUM_FU; i++)
      chk($sformatf("fair_fu%0d", i), 64'(gnt[i] >= 49 && gnt[i] <= 51), 64'(1));

    // Reset mid-operation while both ports are held.
    ifc.arb2rf_write_rdy = 2'b00;
    #1;
    chk("prerst_vld", 64'(ifc.arb2rf_write_vld), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk("arst_vld", 64'(ifc.arb2rf_write_vld), 64'(0));
    chk("arst_rdy", 64'(ifc.fu2arb_write_rdy), 64'(0));
    chk("arst_wb",  64'(ifc.reg_write_back),   64'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, 3'd7, 16'hE000 + 16'(i));
    ifc.arb2rf_write_rdy = 2'b11;
    #1;
    chk("postrst_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b0011));
    tick();

    // Write to register 0 is forwarded but never flagged.
    ifc.fu2arb_write_vld = '0;
    set_fu(1, 1'b1, 3'd0, 16'h5A5A);
    #1;
    chk("r0_gnt", 64'(ifc.fu2arb_write_rdy), 64'(4'b0010));
    tick();
    ifc.fu2arb_write_vld = '0;
    #1;
    chk_port("r0_p0", 0, 1'b1, 1, 0, 16'h5A5A);
    chk("r0_wb", 64'(ifc.reg_write_back), 64'(0));
    tick();
    #1;
    chk("end_idle", 64'(ifc.arb2rf_write_vld), 64'(0));
    chk("end_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
